// File: rtl/mips_mem_stage.sv
// mips_mem_stage: MIPS load/store unit driving an Avalon-style data bus.
// Misaligned or illegal requests bypass the bus and answer with an error.
module mips_mem_stage #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_rt_old,
    output logic [31:0] data_address,
    output logic        data_read,
    output logic        data_write,
    output logic [3:0]  data_byteenable,
    output logic [31:0] data_writedata,
    input  logic        data_waitrequest,
    input  logic [31:0] data_readdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_nx;
    logic [3:0]  op_q;
    logic [31:0] addr_q, wdata_q, rt_q, rdata_q, wait_cnt, mb, ld_res;
    logic [4:0]  sh, shl;
    logic        err_q, acc, bad, last_wait;

    function automatic logic bad_req(input logic [3:0] op, input logic [1:0] a);
        case (op)
            4'd0, 4'd1, 4'd5, 4'd6, 4'd8: bad_req = 1'b0;
            4'd2, 4'd3, 4'd9:             bad_req = a[0];
            4'd4, 4'd10:                  bad_req = a != 2'b00;
            default:                      bad_req = 1'b1;
        endcase
    endfunction

    assign bad       = bad_req(req_op, req_addr[1:0]);
    assign acc       = state == ACCESS;
    assign last_wait = wait_cnt + 32'd1 == MAX_WAIT;
    assign req_ready = state == IDLE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = req_valid ? (bad ? RESP : ACCESS) : IDLE;
            ACCESS:  state_nx = (!data_waitrequest || last_wait) ? RESP : ACCESS;
            default: state_nx = IDLE;
        endcase
    end

    // Bus outputs depend only on registered state, so they hold during waitrequest.
    always_comb begin
        data_read       = acc & ~op_q[3];
        data_write      = acc & op_q[3];
        data_address    = acc ? {addr_q[31:2], 2'b00} : '0;
        data_byteenable = !acc ? 4'b0000 :
                          (op_q == 4'd0 || op_q == 4'd1 || op_q == 4'd8) ? 4'b0001 << addr_q[1:0] :
                          (op_q == 4'd2 || op_q == 4'd3 || op_q == 4'd9) ? 4'b0011 << addr_q[1:0] : 4'b1111;
        data_writedata  = !acc ? '0 :
                          op_q == 4'd8 ? {4{wdata_q[7:0]}} :
                          op_q == 4'd9 ? {2{wdata_q[15:0]}} :
                          op_q == 4'd10 ? wdata_q : '0;
    end

    // sh selects the addressed byte lane; shl is the left-shift that LWL needs.
    always_comb begin
        sh     = {addr_q[1:0], 3'b000};
        shl    = {~addr_q[1:0], 3'b000};
        mb     = data_readdata >> sh;
        ld_res = '0;
        case (op_q)
            4'd0: ld_res = {{24{mb[7]}}, mb[7:0]};
            4'd1: ld_res = {24'b0, mb[7:0]};
            4'd2: ld_res = {{16{mb[15]}}, mb[15:0]};
            4'd3: ld_res = {16'b0, mb[15:0]};
            4'd4: ld_res = data_readdata;
            4'd5: ld_res = (data_readdata << shl) | (rt_q & ((32'd1 << shl) - 32'd1));
            4'd6: ld_res = mb | (rt_q & ~(32'hFFFF_FFFF >> sh));
            default: ld_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            op_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rt_q     <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_valid) begin
                op_q     <= req_op;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                rt_q     <= req_rt_old;
                wait_cnt <= '0;
                err_q    <= bad;
                rdata_q  <= '0;
            end
            if (acc) begin
                if (!data_waitrequest) begin
                    rdata_q <= op_q[3] ? '0 : ld_res;
                end else begin
                    wait_cnt <= wait_cnt + 32'd1;
                    err_q    <= last_wait;
                end
            end
        end
    end

    assign resp_valid = state == RESP;
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign resp_err   = resp_valid & err_q;
endmodule

// File: tb/tb_mips_mem_stage.sv
// tb_mips_mem_stage: directed load/store transactions checked cycle by cycle
// against a byte-level model of the memory stage's expected bus and response.
module tb_mips_mem_stage;
    localparam int MW = 4;
    logic        clk = 0, reset = 0, req_valid = 0, req_ready;
    logic [3:0]  req_op = 0, data_byteenable;
    logic [31:0] req_addr = 0, req_wdata = 0, req_rt_old = 0, data_readdata = 0;
    logic [31:0] data_address, data_writedata, resp_rdata;
    logic        data_read, data_write, data_waitrequest = 0, resp_valid, resp_err;
    int          checks = 0, failures = 0;
    logic        chk_en = 0;
    logic        e_ready, e_read, e_write, e_rv, e_err;
    logic [31:0] e_addr, e_wd, e_rdata, last_rdata, last_wd, last_addr;
    logic [3:0]  e_be, last_be;
    logic        last_err;

    mips_mem_stage #(.MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_rt_old(req_rt_old),
        .data_address(data_address), .data_read(data_read), .data_write(data_write),
        .data_byteenable(data_byteenable), .data_writedata(data_writedata),
        .data_waitrequest(data_waitrequest), .data_readdata(data_readdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("data_read", 32'(data_read), 32'(e_read));
        chk("data_write", 32'(data_write), 32'(e_write));
        chk("data_address", data_address, e_addr);
        chk("data_byteenable", 32'(data_byteenable), 32'(e_be));
        chk("data_writedata", data_writedata, e_wd);
        chk("resp_valid", 32'(resp_valid), 32'(e_rv));
        chk("resp_err", 32'(resp_err), 32'(e_err));
        chk("resp_rdata", resp_rdata, e_rdata);
    end

    function automatic logic is_bad(input logic [3:0] op, input logic [31:0] a);
        case (op)
            4'd0, 4'd1, 4'd5, 4'd6, 4'd8: return 1'b0;
            4'd2, 4'd3, 4'd9:             return a[0];
            4'd4, 4'd10:                  return a[1:0] != 2'b00;
            default:                      return 1'b1;
        endcase
    endfunction

    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'd0, 4'd1, 4'd8: return 1;
            4'd2, 4'd3, 4'd9: return 2;
            default:          return 4;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] a);
        int sz = op_size(op);
        int st = (sz == 4) ? 0 : int'(a[1:0]);
        logic [3:0] be = 0;
        for (int i = 0; i < 4; i++) be[i] = (i >= st) && (i < st + sz);
        return be;
    endfunction

    function automatic logic [31:0] m_wd(input logic [3:0] op, input logic [31:0] w);
        if (op == 4'd8) return {w[7:0], w[7:0], w[7:0], w[7:0]};
        if (op == 4'd9) return {w[15:0], w[15:0]};
        if (op == 4'd10) return w;
        return 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] m, input logic [31:0] rt);
        logic [7:0] mb[4], res[4];
        int k = int'(a[1:0]);
        logic [15:0] h;
        for (int i = 0; i < 4; i++) begin
            mb[i]  = m[8*i +: 8];
            res[i] = rt[8*i +: 8];
        end
        case (op)
            4'd0: return {{24{mb[k][7]}}, mb[k]};
            4'd1: return {24'd0, mb[k]};
            4'd2: begin h = {mb[k+1], mb[k]}; return {{16{h[15]}}, h}; end
            4'd3: begin h = {mb[k+1], mb[k]}; return {16'd0, h}; end
            4'd4: return m;
            4'd5: for (int i = 0; i <= k; i++) res[3-i] = mb[k-i];
            4'd6: for (int i = 0; i <= 3 - k; i++) res[i] = mb[k+i];
            default: return 0;
        endcase
        return {res[3], res[2], res[1], res[0]};
    endfunction

    task automatic set_idle();
        e_ready = 1; e_read = 0; e_write = 0; e_addr = 0; e_be = 0; e_wd = 0;
        e_rv = 0; e_err = 0; e_rdata = 0;
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] w,
                       input logic [31:0] rt, input logic [31:0] m, input int nwait);
        logic bad = is_bad(op, a);
        logic ld = op < 4'd8;
        logic tmo = 0;
        int nacc;
        req_valid = 1; req_op = op; req_addr = a; req_wdata = w; req_rt_old = rt;
        data_readdata = m; data_waitrequest = 0;
        set_idle();
        last_be = 0; last_wd = 0; last_addr = 0;
        @(posedge clk); #1;
        req_valid = 0; req_op = 4'hF; req_addr = 32'hFFFF_FFFF;
        req_wdata = 32'h5A5A_5A5A; req_rt_old = 32'hA5A5_A5A5;
        if (!bad) begin
            tmo = nwait >= MW;
            nacc = tmo ? MW : nwait + 1;
            for (int c = 0; c < nacc; c++) begin
                data_waitrequest = c < nwait;
                data_readdata = data_waitrequest ? 32'hDEAD_0000 : m;
                e_ready = 0; e_read = ld; e_write = !ld; e_addr = {a[31:2], 2'b00};
                e_be = m_be(op, a); e_wd = m_wd(op, w); e_rv = 0; e_err = 0; e_rdata = 0;
                @(negedge clk);
                last_be = data_byteenable; last_wd = data_writedata; last_addr = data_address;
                @(posedge clk); #1;
            end
            data_waitrequest = 0;
        end
        e_ready = 0; e_read = 0; e_write = 0; e_addr = 0; e_be = 0; e_wd = 0;
        e_rv = 1; e_err = bad | tmo;
        e_rdata = (bad | tmo | !ld) ? 32'd0 : m_load(op, a, m, rt);
        @(negedge clk);
        last_rdata = resp_rdata; last_err = resp_err;
        @(posedge clk); #1;
        set_idle();
    endtask

    initial begin
        set_idle();
        repeat (2) @(posedge clk);
        #1 chk_en = 1;
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1;
        run(4'd4, 32'h100, 0, 0, 32'h8899_AABB, 0);
        chk("lw_rdata", last_rdata, 32'h8899_AABB);
        chk("lw_be", {28'd0, last_be}, 32'hF);
        chk("lw_addr", last_addr, 32'h100);
        run(4'd0, 32'h103, 0, 0, 32'h8011_2233, 0);
        chk("lb_rdata", last_rdata, 32'hFFFF_FF80);
        chk("lb_be", {28'd0, last_be}, 32'h8);
        run(4'd1, 32'h103, 0, 0, 32'h8011_2233, 0);
        chk("lbu_rdata", last_rdata, 32'h0000_0080);
        run(4'd9, 32'h202, 32'h1234_ABCD, 0, 32'h7777_7777, 0);
        chk("sh_wd", last_wd, 32'hABCD_ABCD);
        chk("sh_be", {28'd0, last_be}, 32'hC);
        chk("sh_addr", last_addr, 32'h200);
        chk("sh_rdata", last_rdata, 32'h0);
        run(4'd4, 32'h101, 0, 0, 32'h1111_1111, 0);
        chk("lw_mis_err", {31'd0, last_err}, 32'h1);
        run(4'd5, 32'h101, 0, 32'h1122_3344, 32'hAABB_CCDD, 0);
        chk("lwl_rdata", last_rdata, 32'hCCDD_3344);
        run(4'd6, 32'h101, 0, 32'h1122_3344, 32'hAABB_CCDD, 0);
        chk("lwr_rdata", last_rdata, 32'h11AA_BBCC);
        run(4'd4, 32'h104, 0, 0, 32'hCAFE_F00D, 3);
        chk("lw_wait_rdata", last_rdata, 32'hCAFE_F00D);
        run(4'd10, 32'h108, 32'hDEAD_BEEF, 0, 0, 10);
        chk("sw_timeout_err", {31'd0, last_err}, 32'h1);
        run(4'd2, 32'h102, 0, 0, 32'h8011_2233, 0);
        chk("lh_rdata", last_rdata, 32'hFFFF_8011);
        run(4'd3, 32'h100, 0, 0, 32'h8011_2233, 0);
        chk("lhu_rdata", last_rdata, 32'h0000_2233);
        run(4'd8, 32'h101, 32'h0000_00EF, 0, 0, 0);
        chk("sb_wd", last_wd, 32'hEFEF_EFEF);
        chk("sb_be", {28'd0, last_be}, 32'h2);
        run(4'd7, 32'h100, 0, 0, 0, 0);
        chk("illegal_err", {31'd0, last_err}, 32'h1);
        run(4'd9, 32'h203, 32'h1, 0, 0, 0);
        run(4'd10, 32'h10C, 32'h0BAD_F00D, 0, 0, 1);
        run(4'd5, 32'h103, 0, 32'h1122_3344, 32'hAABB_CCDD, 0);
        run(4'd6, 32'h100, 0, 32'h1122_3344, 32'hAABB_CCDD, 2);
        run(4'd6, 32'h103, 0, 32'h1122_3344, 32'hAABB_CCDD, 0);
        chk("lwr3_rdata", last_rdata, 32'h1122_33AA);
        // Reset arriving mid-ACCESS must abort the bus cycle silently.
        req_valid = 1; req_op = 4'd4; req_addr = 32'h300;
        @(posedge clk); #1;
        req_valid = 0; data_waitrequest = 1; reset = 0;
        e_ready = 0; e_read = 1; e_write = 0; e_addr = 32'h300; e_be = 4'hF; e_wd = 0;
        e_rv = 0; e_err = 0; e_rdata = 0;
        @(posedge clk); #1;
        set_idle();
        data_waitrequest = 0;
        @(posedge clk); #1 reset = 1;
        repeat (3) @(posedge clk);
        #1;
        run(4'd4, 32'h100, 0, 0, 32'h0123_4567, 0);
        chk("post_reset_lw", last_rdata, 32'h0123_4567);
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mips_mem_stage.md
MIPS_MEM_STAGE -- requirements
Module: mips_mem_stage

Interface
REQ-001 SHALL have parameter: MAX_WAIT, default 255, number of waitrequest cycles in ACCESS before abort with error.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-low reset (reset=0 at a rising edge resets).
REQ-004 SHALL have port: req_valid  input  1  execute stage presents a load/store.
REQ-005 SHALL have port: req_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have port: req_op  input  4  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 8 SB, 9 SH, 10 SW; other codes are illegal.
REQ-007 SHALL have port: req_addr  input  32  effective byte address.
REQ-008 SHALL have port: req_wdata  input  32  store data (rt).
REQ-009 SHALL have port: req_rt_old  input  32  current rt value for LWL/LWR merge.
REQ-010 SHALL have ports: data_address out 32; data_read out 1; data_write out 1; data_byteenable out 4; data_writedata out 32; data_waitrequest in 1; data_readdata in 32.
REQ-011 SHALL have ports: resp_valid out 1; resp_rdata out 32 (load result); resp_err out 1 (misaligned, illegal op or timeout).

Function
REQ-012 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE, with the IDLE -> RESP bypass for erroring requests.
REQ-013 SHALL assert req_ready=1 only in IDLE; a request is accepted when req_valid & req_ready at a rising edge, latching op, addr, wdata and rt_old.
REQ-014 SHALL, on accept, go to RESP with err=1 and no bus cycle when: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; or an illegal op.
REQ-015 SHALL otherwise go to ACCESS, with data_address={addr[31:2],2'b00} in ACCESS.
REQ-016 SHALL, in ACCESS, assert data_read for loads and data_write for stores, never both; both SHALL be 0 in IDLE and RESP.
REQ-017 SHALL drive data_byteenable in ACCESS, little-endian, k=addr[1:0]:
- byte ops: 1<<k;
- half ops: 4'b0011<<k;
- word, LWL, LWR: 4'b1111.
REQ-018 SHALL drive data_writedata in ACCESS as: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
REQ-019 SHALL hold all bus outputs stable while data_waitrequest=1.
REQ-020 SHALL capture data_readdata on the first ACCESS cycle with data_waitrequest=0, then go to RESP.
REQ-021 SHALL count consecutive waitrequest cycles in ACCESS; when the count reaches MAX_WAIT, it SHALL drop read/write and go to RESP with err=1.
REQ-022 SHALL form load results (m=captured word, k=addr[1:0]):
- LB/LBU: sign/zero-extend m[8k+7:8k];
- LH/LHU: sign/zero-extend m[8k+15:8k];
- LW: m;
- LWL: (m<<8(3-k)) | (rt_old & ((1<<8(3-k))-1));
- LWR: (m>>8k) | (rt_old & ~(32'hFFFFFFFF>>8k)).
REQ-023 SHALL assert resp_valid for exactly one cycle, in RESP.
REQ-024 SHALL keep resp_rdata and resp_err valid only while resp_valid=1; for stores and errors resp_rdata SHALL be 0.
REQ-025 SHALL meet latency with zero wait states: accept at edge N, ACCESS during cycle N+1, resp_valid during N+2; error bypass gives resp_valid during N+1.
REQ-026 SHALL accept no new request while in ACCESS or RESP; the next accept is possible at the edge ending RESP+1 (IDLE).

Reset
REQ-027 SHALL, when reset=0 at an edge, enter IDLE and clear the wait counter.
REQ-028 SHALL, after reset, drive: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, data_read=0, data_write=0, data_byteenable=0, data_address=0, data_writedata=0.
REQ-029 SHALL, on reset during ACCESS, abort the bus cycle (read/write low in the next cycle) and produce no response.

Verification
REQ-030 SHALL pass: LW addr 0x100, mem word 0x8899AABB, waitrequest 0 -> read=1, BE=1111, address 0x100 at N+1; resp_rdata=0x8899AABB, err=0 at N+2.
REQ-031 SHALL pass: LB addr 0x103 and LBU addr 0x103, word 0x80112233 -> 0xFFFFFF80 and 0x00000080; BE=1000.
REQ-032 SHALL pass: SH addr 0x202, wdata 0x1234ABCD -> write=1, BE=1100, writedata 0xABCDABCD, address 0x200.
REQ-033 SHALL pass: LW addr 0x101 -> no read/write ever asserted; resp_valid at N+1 with err=1.
REQ-034 SHALL pass: LWL addr 0x101, rt_old 0x11223344, word 0xAABBCCDD -> 0xCCDD3344; LWR same inputs -> 0x11AABBCC.
REQ-035 SHALL pass: waitrequest held 3 cycles -> bus outputs stable, resp at N+5; waitrequest stuck with MAX_WAIT=4 -> err=1; reset=0 mid-ACCESS -> no resp_valid.
